// File: rtl/mmu_job_scheduler.sv
// mmu_job_scheduler
// Shares one 2x2 matrix-multiply controller between two byte-stream
// requesters. A round-robin winner streams eight operand bytes (A0..A3,
// B0..B3) into the controller's load port. The scheduler then waits for
// compute-done, reads the four result bytes into a local buffer and returns
// them on a valid/ready stream tagged with the winner's id.
//
// Optional build macro: MMU_SCHED_PERF_EN adds saturating job and stall
// counters (jobs_done0, jobs_done1, stall_cycles), each PERF_W bits wide.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | arbitrate between requesters, no byte accepted
// LOAD      | accept 8 operand bytes from the granted requester
// WAIT_DONE | operands loaded, waiting for the controller's done pulse
// GAP       | one dead cycle before the controller enters its output phase
// READ      | four back-to-back output strobes, results captured locally
// RESP      | return the four buffered result bytes to the requester

module mmu_job_scheduler #(
  parameter int PERF_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  input  logic [15:0]       req_data,
  output logic [1:0]        req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [7:0]        rsp_data,
  output logic              rsp_id,
  output logic              rsp_last,
  output logic              busy,
  output logic              mmu_load_en,
  output logic              mmu_load_sel_ab,
  output logic [1:0]        mmu_load_index,
  output logic [7:0]        mmu_in_data,
  output logic              mmu_output_en,
  output logic [1:0]        mmu_output_sel,
  input  logic [7:0]        mmu_out_data,
  input  logic              mmu_done
`ifdef MMU_SCHED_PERF_EN
  ,
  output logic [PERF_W-1:0] jobs_done0,
  output logic [PERF_W-1:0] jobs_done1,
  output logic [PERF_W-1:0] stall_cycles
`endif
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_WAIT_DONE = 3'd2,
    S_GAP       = 3'd3,
    S_READ      = 3'd4,
    S_RESP      = 3'd5
  } state_t;

  state_t      state, state_nxt;
  logic        gnt;
  logic        last_gnt;
  logic        arb_gnt;
  logic [2:0]  byte_idx;
  logic [1:0]  rd_idx;
  logic [1:0]  rsp_idx;
  logic [7:0]  res_buf [4];
  logic        load_accept;
  logic        rsp_hs;

  // Both requesters pending: the one not granted last wins; otherwise the
  // single pending requester wins.
  always_comb begin
    if (req_valid == 2'b11) arb_gnt = ~last_gnt;
    else                    arb_gnt = req_valid[1];
  end

  assign load_accept = (state == S_LOAD) && req_valid[gnt];
  assign rsp_hs      = (state == S_RESP) && rsp_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state selection.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (|req_valid) state_nxt = S_LOAD;
      S_LOAD:      if (load_accept && (byte_idx == 3'd7)) state_nxt = S_WAIT_DONE;
      S_WAIT_DONE: if (mmu_done) state_nxt = S_GAP;
      S_GAP:       state_nxt = S_READ;
      S_READ:      if (rd_idx == 2'd3) state_nxt = S_RESP;
      S_RESP:      if (rsp_hs && (rsp_idx == 2'd3)) state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Grant, job indices and result buffer; last_gnt resets to 1 so that
  // requester 0 wins the first contended arbitration.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt      <= 1'b0;
      last_gnt <= 1'b1;
      byte_idx <= 3'd0;
      rd_idx   <= 2'd0;
      rsp_idx  <= 2'd0;
      for (int i = 0; i < 4; i++) res_buf[i] <= 8'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|req_valid) begin
            gnt      <= arb_gnt;
            last_gnt <= arb_gnt;
          end
          byte_idx <= 3'd0;
          rd_idx   <= 2'd0;
          rsp_idx  <= 2'd0;
        end
        S_LOAD: begin
          if (load_accept) byte_idx <= byte_idx + 3'd1;
        end
        S_READ: begin
          res_buf[rd_idx] <= mmu_out_data;
          rd_idx          <= rd_idx + 2'd1;
        end
        S_RESP: begin
          if (rsp_hs) rsp_idx <= rsp_idx + 2'd1;
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state; load strobe and its fields only while a byte
  // is actually transferred.
  always_comb begin
    req_ready       = 2'b00;
    mmu_load_en     = 1'b0;
    mmu_load_sel_ab = 1'b0;
    mmu_load_index  = 2'd0;
    mmu_in_data     = 8'd0;
    mmu_output_en   = 1'b0;
    mmu_output_sel  = 2'd0;
    rsp_valid       = 1'b0;
    rsp_data        = 8'd0;
    rsp_id          = 1'b0;
    rsp_last        = 1'b0;
    case (state)
      S_LOAD: begin
        req_ready = gnt ? 2'b10 : 2'b01;
        if (req_valid[gnt]) begin
          mmu_load_en     = 1'b1;
          mmu_load_sel_ab = byte_idx[2];
          mmu_load_index  = byte_idx[1:0];
          mmu_in_data     = gnt ? req_data[15:8] : req_data[7:0];
        end
      end
      S_READ: begin
        mmu_output_en  = 1'b1;
        mmu_output_sel = rd_idx;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        rsp_data  = res_buf[rsp_idx];
        rsp_id    = gnt;
        rsp_last  = (rsp_idx == 2'd3);
      end
      default: ;
    endcase
  end

  assign busy = (state != S_IDLE);

`ifdef MMU_SCHED_PERF_EN
  localparam logic [PERF_W-1:0] PERF_MAX = '1;

  logic stall_now;
  assign stall_now = ((state == S_LOAD) && !req_valid[gnt]) ||
                     ((state == S_RESP) && !rsp_ready);

  // Saturating completion and stall counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      jobs_done0   <= '0;
      jobs_done1   <= '0;
      stall_cycles <= '0;
    end else begin
      if (rsp_hs && (rsp_idx == 2'd3)) begin
        if (!gnt && (jobs_done0 != PERF_MAX)) jobs_done0 <= jobs_done0 + 1'b1;
        if (gnt && (jobs_done1 != PERF_MAX))  jobs_done1 <= jobs_done1 + 1'b1;
      end
      if (stall_now && (stall_cycles != PERF_MAX)) stall_cycles <= stall_cycles + 1'b1;
    end
  end
`else
  logic unused_perf_w;
  assign unused_perf_w = ^PERF_W;
`endif

endmodule
